// File: rtl/switch_pkg.sv
// Shared types for the inter-core switch and its per-core endpoints.
// Holds the op kind, the endpoint FSM states and the core-index width helper.
package switch_pkg;

    typedef enum logic {
        SW_SEND = 1'b0,
        SW_RECV = 1'b1
    } switch_op_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_WAIT = 2'd1,
        ST_RECV_WAIT = 2'd2,
        ST_FINISH    = 2'd3
    } endpoint_state_t;

    localparam int SWITCH_WIDTH = 2;

    typedef shortreal switch_payload_t [SWITCH_WIDTH];

    // A single-core switch still needs a one-bit index.
    function automatic int core_addr_size(input int core_size);
        return (core_size > 1) ? $clog2(core_size) : 1;
    endfunction

endpackage

// File: rtl/switch_endpoint_if.sv
// Bundle between a core's control unit, its switch endpoint and the switch port slice.
// master = the endpoint; slave = control unit plus switch port driving the other side.
interface switch_endpoint_if #(
    parameter int WIDTH          = 2,
    parameter int CORE_ADDR_SIZE = 2
);
    // Op side: an op transfers on a clock edge where op_valid and op_ready are both high;
    // op_ready depends only on endpoint state. Switch side: the endpoint holds
    // send_ready/recv_request plus their index/data stable until the edge that sees
    // send_ok/recv_ready, and done pulses one cycle after the op ends.
    logic                      op_valid;
    logic                      op_ready;
    logic                      op_is_recv;
    logic [CORE_ADDR_SIZE-1:0] op_core_idx;
    shortreal                  op_data [WIDTH];
    logic                      done;
    logic                      error;
    shortreal                  result_data [WIDTH];

    logic                      send_ready;
    logic [CORE_ADDR_SIZE-1:0] send_core_idx;
    shortreal                  send_data [WIDTH];
    logic                      send_ok;
    logic                      recv_request;
    logic [CORE_ADDR_SIZE-1:0] recv_core_idx;
    logic                      recv_ready;
    shortreal                  recv_data [WIDTH];

    modport master (
        input  op_valid, op_is_recv, op_core_idx, op_data,
        output op_ready, done, error, result_data,
        output send_ready, send_core_idx, send_data,
        input  send_ok,
        output recv_request, recv_core_idx,
        input  recv_ready, recv_data
    );

    modport slave (
        output op_valid, op_is_recv, op_core_idx, op_data,
        input  op_ready, done, error, result_data,
        input  send_ready, send_core_idx, send_data,
        output send_ok,
        input  recv_request, recv_core_idx,
        output recv_ready, recv_data
    );

endinterface

// File: rtl/switch_wait_timer.sv
// Wait-cycle counter shared by the switch and its endpoints.
// expired is high on the enabled cycle whose edge would bring the count to TIMEOUT.
module switch_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    // Saturates at TIMEOUT; a zero TIMEOUT never counts and never expires.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (TIMEOUT > 0) && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/switch_endpoint.sv
// Core-side master for one switch port: turns single send/receive ops into the
// switch request handshake, with a wait timeout so a missing peer cannot hang the core.
module switch_endpoint
    import switch_pkg::*;
#(
    parameter int WIDTH          = 2,
    parameter int CORE_SIZE      = 3,
    parameter int CORE_IDX       = 0,
    parameter int TIMEOUT        = 64,
    parameter int CORE_ADDR_SIZE = core_addr_size(CORE_SIZE)
) (
    input  logic            clock,
    input  logic            reset,
    switch_endpoint_if.master bus,
    output endpoint_state_t fsm_state
);

    endpoint_state_t           state;
    endpoint_state_t           state_next;
    logic                      error_q;
    logic                      error_next;
    logic [CORE_ADDR_SIZE-1:0] peer_q;
    switch_op_t                op_kind;
    logic                      accept;
    logic                      bad_peer;
    logic                      send_fire;
    logic                      recv_fire;
    logic                      waiting;
    logic                      expired;

    assign op_kind   = switch_op_t'(bus.op_is_recv);
    assign accept    = (state == ST_IDLE) && bus.op_valid;
    assign bad_peer  = (int'(bus.op_core_idx) >= CORE_SIZE) || (int'(bus.op_core_idx) == CORE_IDX);
    assign send_fire = (state == ST_SEND_WAIT) && bus.send_ok;
    assign recv_fire = (state == ST_RECV_WAIT) && bus.recv_ready;
    // Completion suppresses the timer so a completion on the expiring edge wins.
    assign waiting   = ((state == ST_SEND_WAIT) || (state == ST_RECV_WAIT)) && !send_fire && !recv_fire;

    switch_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .enable  (waiting),
        .expired (expired)
    );

    always_comb begin
        state_next = state;
        error_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_peer) begin
                        state_next = ST_FINISH;
                        error_next = 1'b1;
                    end else if (op_kind == SW_RECV) begin
                        state_next = ST_RECV_WAIT;
                    end else begin
                        state_next = ST_SEND_WAIT;
                    end
                end
            end
            ST_SEND_WAIT: begin
                if (send_fire) begin
                    state_next = ST_FINISH;
                end else if (expired) begin
                    state_next = ST_FINISH;
                    error_next = 1'b1;
                end
            end
            ST_RECV_WAIT: begin
                if (recv_fire) begin
                    state_next = ST_FINISH;
                end else if (expired) begin
                    state_next = ST_FINISH;
                    error_next = 1'b1;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            error_q <= 1'b0;
            peer_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                bus.send_data[i]   <= 0.0;
                bus.result_data[i] <= 0.0;
            end
        end else begin
            state   <= state_next;
            error_q <= error_next;
            if (accept && !bad_peer) begin
                peer_q <= bus.op_core_idx;
                if (op_kind == SW_SEND) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        bus.send_data[i] <= bus.op_data[i];
                    end
                end
            end
            if (recv_fire) begin
                for (int i = 0; i < WIDTH; i++) begin
                    bus.result_data[i] <= bus.recv_data[i];
                end
            end
        end
    end

    // Request lines decode from state alone, so they drop on the same edge as completion or reset.
    assign bus.op_ready      = (state == ST_IDLE);
    assign bus.done          = (state == ST_FINISH);
    assign bus.error         = error_q;
    assign bus.send_ready    = (state == ST_SEND_WAIT);
    assign bus.recv_request  = (state == ST_RECV_WAIT);
    assign bus.send_core_idx = peer_q;
    assign bus.recv_core_idx = peer_q;
    assign fsm_state         = state;

endmodule

// File: tb/tb_switch_endpoint.sv
// Directed bench for switch_endpoint: a switch-port responder, an op driver and a
// scoreboard monitor that checks each done pulse against a queued expected response.
module tb_switch_endpoint;
    import switch_pkg::*;

    localparam int WIDTH     = 2;
    localparam int CORE_SIZE = 3;
    localparam int CORE_IDX  = 0;
    localparam int TIMEOUT   = 5;
    localparam int CAS       = core_addr_size(CORE_SIZE);

    typedef struct {
        logic error;
        real  d0;
        real  d1;
        int   req_cycles;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    endpoint_state_t fsm_state;

    switch_endpoint_if #(.WIDTH(WIDTH), .CORE_ADDR_SIZE(CAS)) bus ();

    switch_endpoint #(
        .WIDTH     (WIDTH),
        .CORE_SIZE (CORE_SIZE),
        .CORE_IDX  (CORE_IDX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clock = ~clock;

    exp_t           exp_q[$];
    int             checks   = 0;
    int             failures = 0;
    int             resp_delay = -1;
    real            resp_d0 = 0.0, resp_d1 = 0.0;
    logic [CAS-1:0] exp_dest = '0;
    real            model_d0 = 0.0, model_d1 = 0.0;
    bit             force_ok = 1'b0;
    int             wcnt = 0;
    int             req_cnt = 0;
    bit             after_done = 1'b0;
    bit             hit;

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_real(input string name, input real act, input real req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %f expected %f at %0t", name, act, req, $time);
        end
    endtask

    // Switch port model: raises send_ok/recv_ready on wait cycle resp_delay (-1 = never).
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                bus.send_ok    = 1'b0;
                bus.recv_ready = 1'b0;
                wcnt           = 0;
            end else if (force_ok) begin
                bus.send_ok    = 1'b1;
                bus.recv_ready = 1'b0;
            end else if (bus.send_ready || bus.recv_request) begin
                hit = (resp_delay >= 0) && (wcnt == resp_delay);
                bus.send_ok       = bus.send_ready && hit;
                bus.recv_ready    = bus.recv_request && hit;
                bus.recv_data[0]  = hit ? resp_d0 : -99.0;
                bus.recv_data[1]  = hit ? resp_d1 : -99.0;
                if (bus.send_ready) begin
                    check_int("send_core_idx", int'(bus.send_core_idx), int'(exp_dest));
                    check_real("send_data0", bus.send_data[0], resp_d0);
                    check_real("send_data1", bus.send_data[1], resp_d1);
                end else begin
                    check_int("recv_core_idx", int'(bus.recv_core_idx), int'(exp_dest));
                end
                wcnt++;
            end else begin
                bus.send_ok    = 1'b0;
                bus.recv_ready = 1'b0;
                wcnt           = 0;
            end
        end
    end

    // Scoreboard monitor: every done pulse pops one expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                req_cnt    = 0;
                after_done = 1'b0;
            end else begin
                check_int("exclusive_req", int'(bus.send_ready & bus.recv_request), 0);
                if (after_done) check_int("op_ready_after_done", int'(bus.op_ready), 1);
                after_done = 1'b0;
                if (bus.send_ready || bus.recv_request) req_cnt++;
                if (bus.done) begin
                    check_int("op_ready_in_finish", int'(bus.op_ready), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done=1 expected no op pending at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check_int("error", int'(bus.error), int'(e.error));
                        check_real("result_data0", bus.result_data[0], e.d0);
                        check_real("result_data1", bus.result_data[1], e.d1);
                        check_int("req_cycles", req_cnt, e.req_cycles);
                    end
                    req_cnt    = 0;
                    after_done = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.op_ready !== 1'b1 && n < 100) begin
            @(posedge clock); #2;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL op_ready_wait: got op_ready=0 expected 1 within 100 cycles");
        end
    endtask

    // Issues one op; d0/d1 are the send payload or the data the switch returns for a receive.
    task automatic do_op(input bit is_recv, input int idx, input real d0, input real d1,
                         input int delay, input bit expect_it);
        exp_t e;
        bit   bad;
        bit   ok;
        wait_ready();
        resp_delay = delay;
        resp_d0    = d0;
        resp_d1    = d1;
        exp_dest   = CAS'(idx);
        bad = (idx >= CORE_SIZE) || (idx == CORE_IDX);
        ok  = !bad && (delay >= 0) && (delay < TIMEOUT);
        if (ok && is_recv) begin
            model_d0 = d0;
            model_d1 = d1;
        end
        e.error      = !ok;
        e.d0         = model_d0;
        e.d1         = model_d1;
        e.req_cycles = bad ? 0 : (ok ? delay + 1 : TIMEOUT);
        if (expect_it) exp_q.push_back(e);
        bus.op_valid    = 1'b1;
        bus.op_is_recv  = is_recv;
        bus.op_core_idx = CAS'(idx);
        bus.op_data[0]  = d0;
        bus.op_data[1]  = d1;
        @(posedge clock); #2;
        bus.op_valid    = 1'b0;
        bus.op_data[0]  = -7.0;
        bus.op_data[1]  = -7.0;
    endtask

    initial begin
        int n;
        reset           = 1'b1;
        bus.op_valid    = 1'b0;
        bus.op_is_recv  = 1'b0;
        bus.op_core_idx = '0;
        bus.op_data[0]  = 0.0;
        bus.op_data[1]  = 0.0;
        bus.send_ok     = 1'b0;
        bus.recv_ready  = 1'b0;
        bus.recv_data[0] = 0.0;
        bus.recv_data[1] = 0.0;
        repeat (3) @(posedge clock);
        #2;
        check_int("rst_op_ready", int'(bus.op_ready), 1);
        check_int("rst_send_ready", int'(bus.send_ready), 0);
        check_int("rst_recv_request", int'(bus.recv_request), 0);
        check_int("rst_done", int'(bus.done), 0);
        check_int("rst_error", int'(bus.error), 0);
        check_int("rst_send_core_idx", int'(bus.send_core_idx), 0);
        check_real("rst_result_data0", bus.result_data[0], 0.0);
        check_real("rst_send_data0", bus.send_data[0], 0.0);
        reset = 1'b0;
        @(posedge clock); #2;

        // is_recv, peer, data0, data1, response delay (-1 = never), scoreboarded
        do_op(1'b0, 1, 11.0, 13.0,  0, 1'b1);
        do_op(1'b1, 2, 11.0, 13.0,  4, 1'b1);
        do_op(1'b0, 0,  5.0,  6.0,  0, 1'b1);
        do_op(1'b0, 3,  5.0,  6.0,  0, 1'b1);
        do_op(1'b1, 1, 99.0, 98.0, -1, 1'b1);
        do_op(1'b1, 1, 21.0, 23.0,  2, 1'b1);
        do_op(1'b0, 2,  1.0,  2.0, -1, 1'b1);
        do_op(1'b1, 2,  1.5, -2.5,  0, 1'b1);
        do_op(1'b1, 0,  7.0,  7.0,  0, 1'b1);
        do_op(1'b1, 3,  7.0,  7.0,  1, 1'b1);
        do_op(1'b0, 2,  4.0,  8.0,  3, 1'b1);
        do_op(1'b1, 1, 31.0, 33.0,  5, 1'b1);
        wait_ready();

        force_ok = 1'b1;
        repeat (4) begin
            @(posedge clock); #2;
            check_int("idle_send_ok_state", int'(fsm_state), int'(ST_IDLE));
        end
        force_ok = 1'b0;
        @(posedge clock); #2;

        do_op(1'b0, 1, 3.0, 4.0, -1, 1'b0);
        @(posedge clock); #2;
        check_int("mid_op_state", int'(fsm_state), int'(ST_SEND_WAIT));
        reset = 1'b1;
        @(posedge clock); #2;
        check_int("mid_rst_send_ready", int'(bus.send_ready), 0);
        check_int("mid_rst_recv_request", int'(bus.recv_request), 0);
        check_int("mid_rst_done", int'(bus.done), 0);
        check_int("mid_rst_error", int'(bus.error), 0);
        check_int("mid_rst_send_core_idx", int'(bus.send_core_idx), 0);
        check_int("mid_rst_recv_core_idx", int'(bus.recv_core_idx), 0);
        check_real("mid_rst_send_data0", bus.send_data[0], 0.0);
        check_real("mid_rst_send_data1", bus.send_data[1], 0.0);
        check_real("mid_rst_result_data0", bus.result_data[0], 0.0);
        check_real("mid_rst_result_data1", bus.result_data[1], 0.0);
        check_int("mid_rst_state", int'(fsm_state), int'(ST_IDLE));
        reset = 1'b0;
        @(posedge clock); #2;
        check_int("post_rst_op_ready", int'(bus.op_ready), 1);
        repeat (8) @(posedge clock);

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL pending_ops: got %0d outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/switch_endpoint.md
Name: switch_endpoint

Overview:
- Core-side master for one port of the inter-core switch. Converts single send/receive ops from the core's control unit into the switch handshake: drives send_ready/send_core_idx/send_data, waits for send_ok; drives recv_request/recv_core_idx, waits for recv_ready and captures recv_data.
- One instance per core, between the core's vector register file / control FSM and the switch's per-core port slice.
- Adds a wait timeout so a missing peer cannot hang the core.

Parameters:
- WIDTH, 2, shortreal lanes per transfer; must equal the switch WIDTH.
- CORE_SIZE, 3, number of cores on the switch.
- CORE_IDX, 0, this core's own index; self-addressed ops are rejected.
- TIMEOUT, 64, maximum wait cycles per op (≥1); 0 disables the timeout.
- CORE_ADDR_SIZE, $clog2(CORE_SIZE), derived width of a core index.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  control unit presents an op
- op_ready  out  1  endpoint can accept an op (high only in IDLE)
- op_is_recv  in  1  0 = send, 1 = receive
- op_core_idx  in  CORE_ADDR_SIZE  peer core index
- op_data  in  WIDTH x shortreal  payload for a send
- done  out  1  one-cycle pulse when an op finishes, success or error
- error  out  1  valid with done: timeout or bad peer
- result_data  out  WIDTH x shortreal  last received payload; holds until the next successful receive
- send_ready  out  1  to switch: send request
- send_core_idx  out  CORE_ADDR_SIZE  to switch: destination core
- send_data  out  WIDTH x shortreal  to switch: payload
- send_ok  in  1  from switch: send accepted
- recv_request  out  1  to switch: receive request
- recv_core_idx  out  CORE_ADDR_SIZE  to switch: source core
- recv_ready  in  1  from switch: data available
- recv_data  in  WIDTH x shortreal  from switch: payload

Behaviour:
- All state is registered on posedge clock. reset has priority over every other input.
- On reset: state = IDLE; send_ready = 0, recv_request = 0; send_core_idx = 0, recv_core_idx = 0; send_data = 0.0, result_data = 0.0; done = 0, error = 0; wait counter = 0.
- A reset in the middle of an op drops the request line in the same edge. No done pulse is produced.
- FSM states: IDLE, SEND_WAIT, RECV_WAIT, FINISH.
- IDLE:
  - op_ready = 1.
  - Accept when op_valid = 1.
  - If op_core_idx ≥ CORE_SIZE or op_core_idx == CORE_IDX, go to FINISH with error = 1. No switch request is issued.
  - Otherwise latch op_core_idx (and op_data for a send), clear the counter, and go to SEND_WAIT or RECV_WAIT.
  - The request line rises on the cycle after acceptance.
- SEND_WAIT:
  - send_ready = 1. send_core_idx and send_data are held stable.
  - The transfer completes on the first edge where send_ready = 1 and send_ok = 1. send_ready drops on that edge; go to FINISH with error = 0.
  - An isolated send_ok while not in SEND_WAIT is ignored.
- RECV_WAIT:
  - recv_request = 1. recv_core_idx is held stable.
  - The transfer completes on the first edge where recv_request = 1 and recv_ready = 1. recv_data is captured into result_data on that edge; recv_request drops; go to FINISH with error = 0.
- Timeout:
  - The counter increments on each wait cycle without completion.
  - When the counter reaches TIMEOUT, the request drops and the FSM goes to FINISH with error = 1. result_data is unchanged.
  - If completion and the timeout occur on the same edge, completion wins.
- FINISH:
  - done = 1 (and error as set) for exactly one cycle.
  - op_ready = 0. Next state is IDLE.
  - Minimum op latency: accept edge → request high → earliest completion edge → done visible one cycle later.
- At most one op is in flight. send_ready and recv_request are never high together.
- Ready/valid on the op interface is not combinationally dependent on switch inputs.

Decomposition:
- Package switch_pkg holds:
  - switch_op_t (enum SW_SEND, SW_RECV);
  - endpoint state enum;
  - localparam function core_addr_size(CORE_SIZE);
  - the shared switch_payload_t typedef (shortreal [WIDTH]).
- One sub-module, switch_wait_timer: a TIMEOUT-parameterised counter with clear, enable and expired; it is reused by the switch itself.

Test Plan:
- Send, immediate accept: from IDLE, op send to core 1 with data {11,13}; switch holds send_ok = 1 → send_ready high for 1 cycle with send_core_idx = 1 and send_data = {11,13}; done = 1, error = 0 on the following cycle.
- Receive, delayed data: op recv from core 2; recv_ready stays 0 for 4 cycles, then is 1 with recv_data = {11,13} → recv_request is high for 5 cycles, result_data = {11,13}, done pulse with error = 0, op_ready returns to 1 the next cycle.
- Bad peer: op with op_core_idx = CORE_IDX (0), then a second op with op_core_idx = 3 → no request is asserted; done and error pulse 1 cycle after acceptance in both cases.
- Timeout: TIMEOUT = 5, op recv with recv_ready never asserted → recv_request is high for exactly 5 cycles, then done = 1 and error = 1; result_data is unchanged from its prior value.
- Race and exclusivity: recv_ready asserted on the same edge the timeout expires → success; result_data captured, error = 0. Across back-to-back random ops, send_ready & recv_request is never 1.
- Reset mid-op: reset asserted while in SEND_WAIT → on the next edge send_ready = 0, all outputs are at their reset values, op_ready = 1 after reset deasserts, and no done pulse appears.
